// File: rtl/insn_fetch.sv
`default_nettype none
// ============================================================================
// Module   : insn_fetch
// Brief    : Word-addressed instruction prefetcher. It has a small FIFO, handles
//            redirects and keeps a sticky fetch-fault flag.
// Revision : 1.0 - initial release
// ============================================================================
module insn_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    input  logic [31:0] mem_line,
    input  logic        mem_rrdy,
    input  logic        mem_exc,
    output logic [31:0] insn,
    output logic [31:0] insn_pc,
    output logic        insn_valid,
    input  logic        insn_ready,
    input  logic        redir,
    input  logic [31:0] redir_addr,
    output logic        fault,
    output logic [31:0] fault_addr
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_mem_read;
    logic [31:0]          r_fetch_pc;
    logic [31:0]          r_target;
    logic                 r_drop;
    logic                 r_fault;
    logic [31:0]          r_fault_addr;

    logic [31:0]          r_buf_data [DEPTH];
    logic [31:0]          r_buf_pc   [DEPTH];
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_cnt_w-1:0]   r_count;

    logic                 w_done;
    logic                 w_push;
    logic                 w_pop;
    logic [c_cnt_w-1:0]   w_cnt_next;
    logic                 w_space;

    // A read completes on rrdy or exc; the data is discarded when the read was redirected.
    assign w_done     = r_mem_read & (mem_rrdy | mem_exc);
    assign w_push     = w_done & ~mem_exc & ~r_drop & ~redir;
    assign w_pop      = insn_valid & insn_ready & ~redir;
    assign w_cnt_next = r_count + {{(c_cnt_w-1){1'b0}}, w_push}
                                - {{(c_cnt_w-1){1'b0}}, w_pop};
    assign w_space    = (w_cnt_next < c_depth);

    assign mem_addr   = r_fetch_pc;
    assign mem_read   = r_mem_read;
    assign fault      = r_fault;
    assign fault_addr = r_fault_addr;
    assign insn_valid = (r_count != '0);
    assign insn       = insn_valid ? r_buf_data[r_rd_ptr] : 32'h0;
    assign insn_pc    = insn_valid ? r_buf_pc[r_rd_ptr]   : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_mem_read   <= 1'b0;
            r_fetch_pc   <= RESET_PC;
            r_target     <= RESET_PC;
            r_drop       <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_addr <= 32'h0;
        end else if (redir) begin
            r_fault <= 1'b0;
            // Memory cannot abort a read, so keep it open and discard it when it completes.
            if (r_state == S_REQ && !w_done) begin
                r_drop   <= 1'b1;
                r_target <= redir_addr;
            end else begin
                r_state    <= S_IDLE;
                r_mem_read <= 1'b0;
                r_drop     <= 1'b0;
                r_fetch_pc <= redir_addr;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_space) begin
                        r_state    <= S_REQ;
                        r_mem_read <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (w_done) begin
                        if (r_drop) begin
                            r_drop     <= 1'b0;
                            r_fetch_pc <= r_target;
                        end else if (mem_exc) begin
                            r_fault      <= 1'b1;
                            r_fault_addr <= r_fetch_pc;
                            r_state      <= S_FAULT;
                            r_mem_read   <= 1'b0;
                        end else begin
                            r_fetch_pc <= r_fetch_pc + 32'd1;
                            if (!w_space) begin
                                r_state    <= S_IDLE;
                                r_mem_read <= 1'b0;
                            end
                        end
                    end
                end
                S_FAULT: begin
                    r_mem_read <= 1'b0;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_mem_read <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || redir) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_buf_data[r_wr_ptr] <= mem_line;
                r_buf_pc[r_wr_ptr]   <= r_fetch_pc;
                r_wr_ptr             <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            r_count <= w_cnt_next;
        end
    end

endmodule
`default_nettype wire

// File: doc/insn_fetch.md
INSN_FETCH -- requirements
Module: insn_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0, word address fetched first after reset.
REQ-002 Parameter DEPTH, default 2, prefetch buffer entries; power of two, 2..8.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 mem_addr  output  32  word read address to instruction memory.
REQ-006 mem_read  output  1  read request; held high until completion.
REQ-007 mem_line  input  32  read data; valid in the cycle mem_rrdy=1 with mem_read=1.
REQ-008 mem_rrdy  input  1  read completion strobe.
REQ-009 mem_exc  input  1  read exception; terminates the request as a fault.
REQ-010 insn  output  32  instruction word to decode; 32'h0 (nop) when insn_valid=0.
REQ-011 insn_pc  output  32  word address of insn; 32'h0 when insn_valid=0.
REQ-012 insn_valid  output  1  buffer head holds a valid word.
REQ-013 insn_ready  input  1  decode accepts head this cycle.
REQ-014 redir  input  1  branch/return redirect request.
REQ-015 redir_addr  input  32  new fetch word address.
REQ-016 fault  output  1  sticky fetch fault flag.
REQ-017 fault_addr  output  32  word address whose read raised mem_exc.

Function
REQ-018 Word-addressed fetch: fetch_pc increments by 1 per accepted read, 32-bit wrap (32'hFFFFFFFF -> 32'h0), no flag.
REQ-019 States: IDLE, REQ, FAULT; mem_read=1 only in REQ; at most one outstanding read.
REQ-020 IDLE -> REQ when buffer has a free slot (counting one slot reserved per outstanding read) and not FAULT; mem_addr=fetch_pc, stable while in REQ.
REQ-021 REQ, mem_rrdy=1, mem_exc=0: {mem_line, mem_addr} pushed to buffer tail same edge, fetch_pc+1; back-to-back request next cycle if space remains (REQ -> REQ, mem_read deasserts for 0 cycles allowed only if a slot is free).
REQ-022 REQ, mem_exc=1 (priority over mem_rrdy): no push, fault=1, fault_addr=mem_addr, -> FAULT.
REQ-023 FAULT: no further reads; buffered words still drain to decode; leaves FAULT only via redir or rst.
REQ-024 insn/insn_pc/insn_valid driven combinationally from buffer head; head pops on insn_valid & insn_ready.
REQ-025 Push and pop same cycle on a full buffer allowed only if pop occurs; no overflow, no underflow; insn_ready with empty buffer ignored.
REQ-026 Minimum latency: mem_rrdy at edge N -> insn_valid=1 after edge N (one-cycle fill latency).
REQ-027 redir=1: buffer flushed, fetch_pc=redir_addr, fault cleared, FAULT -> IDLE, same edge; pop on that edge suppressed; insn_valid=0 the following cycle.
REQ-028 redir while in REQ: mem_read stays high (memory cannot abort); that read's data/exception discarded on completion (drop flag), then new read at redir_addr issued next cycle.
REQ-029 redir during a drop-pending read: target updated to newest redir_addr, still exactly one discarded completion.
REQ-030 redir has priority over simultaneous push, pop and fault capture.

Reset
REQ-031 On rst=1 at an edge: fetch_pc=RESET_PC, state=IDLE, buffer empty, drop flag clear, fault=0, fault_addr=0.
REQ-032 During/after reset edge: mem_read=0, mem_addr=RESET_PC, insn=0, insn_pc=0, insn_valid=0.
REQ-033 rst mid-read: outstanding read abandoned; a late mem_rrdy/mem_exc with mem_read=0 ignored.
REQ-034 rst has priority over redir and all other inputs.

Verification
REQ-035 Reset, memory answers rrdy one cycle after each read, insn_ready=1: addresses 0,1,2,3 read in order; insn_pc 0,1,2,3 with matching mem_line.
REQ-036 insn_ready=0 for 10 cycles: exactly DEPTH words buffered, mem_read low afterward; release -> words delivered in order, no loss/duplication.
REQ-037 redir to 32'h134 while read of addr 5 outstanding: addr-5 data discarded, next insn_pc=32'h134, next mem_addr=32'h135.
REQ-038 mem_exc on addr 7: fault=1, fault_addr=7, no further reads, buffered 5,6 drain; redir to 0 clears fault, fetch resumes at 0.
REQ-039 redir_addr=32'hFFFFFFFF: fetches 32'hFFFFFFFF then 32'h0.
REQ-040 rst asserted with read outstanding and two words buffered: next cycle insn_valid=0, mem_read=0, then fetch restarts at RESET_PC.
